// File: rtl/hist_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hist_pkg                                                      |
// | Purpose  : Shared constants and state encoding for the histogram block.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package hist_pkg;

  localparam int NUM_BINS = 256;
  localparam int PIX_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hist_bin_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hist_bin_mem                                                  |
// | Purpose  : Bin storage: one write port, combinational RMW read port and  |
// |            a registered read-back port.                                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module hist_bin_mem
  import hist_pkg::*;
#(
  parameter int COUNT_BIT = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [PIX_W-1:0]     i_waddr,
  input  logic [COUNT_BIT-1:0] i_wdata,
  input  logic [PIX_W-1:0]     i_raddr_a,
  output logic [COUNT_BIT-1:0] o_rdata_a,
  input  logic [PIX_W-1:0]     i_rd_addr,
  output logic [COUNT_BIT-1:0] o_rd_data
);

  // Contents are deliberately not reset; a CLEAR pass initialises them.
  logic [COUNT_BIT-1:0] r_bins [NUM_BINS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_bins[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_bins[i_raddr_a];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_data <= '0;
    end else begin
      o_rd_data <= r_bins[i_rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/hist_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hist_ctrl                                                     |
// | Purpose  : Clears 256 bins, scans the frame RAM and builds a grey-level  |
// |            histogram. Optional HIST_MAXBIN_EN adds max-bin tracking.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module hist_ctrl
  import hist_pkg::*;
#(
  parameter int W               = 2,
  parameter int H               = 5,
  parameter int TOTAL_PIXEL     = W * H,
  parameter int TOTAL_PIXEL_BIT = $clog2(W * H),
  parameter int COUNT_BIT       = TOTAL_PIXEL_BIT + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [TOTAL_PIXEL_BIT-1:0] ram_rd_addr,
  input  logic [PIX_W-1:0]           ram_rd_data,
  input  logic [PIX_W-1:0]           hist_rd_addr,
  output logic [COUNT_BIT-1:0]       hist_rd_data
`ifdef HIST_MAXBIN_EN
  ,
  output logic [COUNT_BIT-1:0]       max_cnt,
  output logic [PIX_W-1:0]           max_bin
`endif
);

  localparam logic [TOTAL_PIXEL_BIT-1:0] C_LAST_ADDR = TOTAL_PIXEL_BIT'(TOTAL_PIXEL - 1);
  localparam logic [PIX_W-1:0]           C_LAST_BIN  = PIX_W'(NUM_BINS - 1);

  state_t                     r_state;
  state_t                     w_next;
  logic [PIX_W-1:0]           r_clr_idx;
  logic [TOTAL_PIXEL_BIT-1:0] r_addr;
  logic                       r_vld;
  logic                       w_we;
  logic [PIX_W-1:0]           w_waddr;
  logic [COUNT_BIT-1:0]       w_wdata;
  logic [COUNT_BIT-1:0]       w_cur_cnt;
  logic [COUNT_BIT-1:0]       w_inc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    ram_rd_addr = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        busy = 1'b1;
        if (r_clr_idx == C_LAST_BIN) w_next = S_SCAN;
      end
      S_SCAN: begin
        busy        = 1'b1;
        ram_rd_addr = r_addr;
        if (r_addr == C_LAST_ADDR) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_vld marks the cycle in which the RAM returns data for an issued address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_idx <= '0;
      r_addr    <= '0;
      r_vld     <= 1'b0;
    end else begin
      r_clr_idx <= (r_state == S_CLEAR) ? r_clr_idx + 1'b1 : '0;
      r_addr    <= (r_state == S_SCAN)  ? r_addr + 1'b1    : '0;
      r_vld     <= (r_state == S_SCAN);
    end
  end

  assign w_inc_cnt = w_cur_cnt + 1'b1;
  assign w_we      = (r_state == S_CLEAR) || r_vld;
  assign w_waddr   = (r_state == S_CLEAR) ? r_clr_idx : ram_rd_data;
  assign w_wdata   = (r_state == S_CLEAR) ? '0 : w_inc_cnt;

  hist_bin_mem #(
    .COUNT_BIT (COUNT_BIT)
  ) u_bin_mem (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (ram_rd_data),
    .o_rdata_a (w_cur_cnt),
    .i_rd_addr (hist_rd_addr),
    .o_rd_data (hist_rd_data)
  );

`ifdef HIST_MAXBIN_EN
  logic [COUNT_BIT-1:0] r_max_cnt;
  logic [PIX_W-1:0]     r_max_bin;

  // Strict compare keeps the earliest bin on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_cnt <= '0;
      r_max_bin <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_max_cnt <= '0;
      r_max_bin <= '0;
    end else if (r_vld && (w_inc_cnt > r_max_cnt)) begin
      r_max_cnt <= w_inc_cnt;
      r_max_bin <= ram_rd_data;
    end
  end

  assign max_cnt = r_max_cnt;
  assign max_bin = r_max_bin;
`else
  // Max-bin tracking is not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_hist_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hist_ctrl                                                  |
// | Purpose  : Self-checking bench for hist_ctrl (HIST_MAXBIN_EN optional).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_hist_ctrl;

  localparam int TP  = 10;
  localparam int TPB = 4;
  localparam int CB  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           done;
  logic [TPB-1:0] ram_rd_addr;
  logic [7:0]     ram_rd_data;
  logic [7:0]     hist_rd_addr;
  logic [CB-1:0]  hist_rd_data;
`ifdef HIST_MAXBIN_EN
  logic [CB-1:0]  max_cnt;
  logic [7:0]     max_bin;
`endif

  hist_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .hist_rd_addr (hist_rd_addr),
    .hist_rd_data (hist_rd_data)
`ifdef HIST_MAXBIN_EN
    ,
    .max_cnt      (max_cnt),
    .max_bin      (max_bin)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] tb_ram [TP];
  always @(posedge clk) ram_rd_data <= tb_ram[ram_rd_addr];

  int n_checks = 0;
  int n_errors = 0;
  int exp_hist [256];
  int exp_max_cnt;
  int exp_max_bin;
  logic [CB-1:0] got_hist [256];

  typedef struct {
    logic [7:0]  bin;
    logic [31:0] cnt;
  } bin_vec_t;
  bin_vec_t vec [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: histogram and first-to-reach maximum straight from the pixel list.
  task automatic build_model();
    for (int b = 0; b < 256; b++) exp_hist[b] = 0;
    exp_max_cnt = 0;
    exp_max_bin = 0;
    for (int i = 0; i < TP; i++) begin
      exp_hist[tb_ram[i]]++;
      if (exp_hist[tb_ram[i]] > exp_max_cnt) begin
        exp_max_cnt = exp_hist[tb_ram[i]];
        exp_max_bin = int'(tb_ram[i]);
      end
    end
  endtask

  task automatic read_bin(input logic [7:0] b, output logic [CB-1:0] v);
    @(negedge clk) hist_rd_addr = b;
    @(posedge clk);
    #1 v = hist_rd_data;
  endtask

  task automatic compare_hist(input string name);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    build_model();
    for (int b = 0; b < 256; b++) begin
      read_bin(8'(b), got_hist[b]);
      if (got_hist[b] !== CB'(exp_hist[b])) begin
        bad++;
        if (first < 0) first = b;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL %s: %0d bins wrong, bin %0h got %0h expected %0h",
               name, bad, first, got_hist[first], exp_hist[first]);
    end
`ifdef HIST_MAXBIN_EN
    check({name, "_max_cnt"}, 32'(max_cnt), 32'(exp_max_cnt));
    check({name, "_max_bin"}, 32'(max_bin), 32'(exp_max_bin));
`endif
  endtask

  task automatic table_check();
    logic [CB-1:0] v;
    for (int i = 0; i < 13; i++) begin
      read_bin(vec[i].bin, v);
      check($sformatf("bin_%02h", vec[i].bin), 32'(v), vec[i].cnt);
    end
  endtask

  task automatic run_frame(input bit inject_start);
    int dones;
    int done_k;
    int bad_addr;
    logic [31:0] exp_addr;
    dones    = 0;
    done_k   = -1;
    bad_addr = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    if (ram_rd_addr !== '0) bad_addr++;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      exp_addr = (k >= 256 && k <= 265) ? 32'(k - 256) : 32'd0;
      if (32'(ram_rd_addr) !== exp_addr) bad_addr++;
      if (inject_start && k == 260) start = 1'b1;
      if (k == 261) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      if (k >= 275) break;
    end
    check("done_latency", 32'(done_k), 32'd267);
    check("done_pulses", 32'(dones), 32'd1);
    check("addr_seq_bad", 32'(bad_addr), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_abort();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      @(posedge clk);
      #1;
    end
    check("abort_scan_addr", 32'(ram_rd_addr), 32'd4);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr", 32'(ram_rd_addr), 32'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic load_default();
    for (int i = 0; i < TP; i++) tb_ram[i] = 8'((i + 1) * 8'h11);
  endtask

  initial begin
    vec[0]  = '{8'h00, 32'd0};
    vec[1]  = '{8'h11, 32'd1};
    vec[2]  = '{8'h22, 32'd1};
    vec[3]  = '{8'h33, 32'd1};
    vec[4]  = '{8'h44, 32'd1};
    vec[5]  = '{8'h55, 32'd1};
    vec[6]  = '{8'h66, 32'd1};
    vec[7]  = '{8'h77, 32'd1};
    vec[8]  = '{8'h88, 32'd1};
    vec[9]  = '{8'h99, 32'd1};
    vec[10] = '{8'hAA, 32'd1};
    vec[11] = '{8'hFF, 32'd0};
    vec[12] = '{8'hAB, 32'd0};

    rst          = 1'b1;
    start        = 1'b0;
    hist_rd_addr = 8'h00;
    load_default();
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(ram_rd_addr), 32'd0);
    check("rst_hist_rd", 32'(hist_rd_data), 32'd0);
`ifdef HIST_MAXBIN_EN
    check("rst_max_cnt", 32'(max_cnt), 32'd0);
    check("rst_max_bin", 32'(max_bin), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    run_frame(1'b0);
    table_check();
`ifdef HIST_MAXBIN_EN
    check("dflt_max_cnt", 32'(max_cnt), 32'd1);
    check("dflt_max_bin", 32'(max_bin), 32'h11);
`endif

    run_frame(1'b1);
    compare_hist("second_run");

    for (int i = 0; i < TP; i++) tb_ram[i] = 8'h5A;
    run_frame(1'b0);
    begin
      logic [CB-1:0] v;
      read_bin(8'h5A, v);
      check("bin_5a_all", 32'(v), 32'd10);
    end
    compare_hist("all_5a");

    load_default();
    run_abort();
    run_frame(1'b0);
    table_check();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < TP; i++) begin
        if (r[0]) tb_ram[i] = 8'h40 + 8'($urandom_range(0, 3));
        else      tb_ram[i] = 8'($urandom_range(0, 255));
      end
      run_frame(1'b0);
      compare_hist($sformatf("rand_%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
